bpu_update_sched: RTL and testbench
===================================

BPU_UPDATE_SCHED -- requirements
Module: bpu_update_sched

Interface
REQ-001 Parameter QDEPTH, default 64, is the number of BPU queue entries.
REQ-002 Parameter PTRW, default 7, is the pointer width: log2(QDEPTH) index bits plus 1 wrap bit.
REQ-003 Clk  in  1  single clock; all state on rising edge.
REQ-004 Rest  in  1  reset, asynchronous, active-low.
REQ-005 FetchTQStop  in  1  stalls new allocation.
REQ-006 FetchTQFlash  in  1  one-cycle pipeline flush pulse.
REQ-007 FlashPtr  in  PTRW  write pointer to restore on flush.
REQ-008 AllocAble  in  1  predictor writes one entry at WritePtr this cycle.
REQ-009 Inst1Commit..Inst4Commit  in  1 each  ROB commit flags, one per committed queue entry.
REQ-010 RdType  in  3  type of the queue entry at UpdPtr index, combinational from queue storage.
REQ-011 FetchReq  out  1  allocation permitted.
REQ-012 WritePtr, CommitPtr, UpdPtr  out  PTRW each  allocation, commit and update pointers.
REQ-013 QueueFull, QueueEmpty  out  1 each  occupancy flags.
REQ-014 UpBtbAble, UpRasAble, UpTageAble  out  1 each  predictor update strobes for the entry at UpdPtr.
REQ-015 UpRasReLoad, UpTageReLoad  out  1 each  speculative-state reload strobes.
REQ-016 CommitErr  out  1  sticky flag: over-commit detected.

Function
REQ-017 The block SHALL keep the ordering UpdPtr <= CommitPtr <= WritePtr, with modulo 2^PTRW distance.
REQ-018 Occupancy = WritePtr - UpdPtr (PTRW-bit modulo); QueueFull SHALL be 1 when occupancy = QDEPTH, and QueueEmpty SHALL be 1 when occupancy = 0.
REQ-019 FetchReq SHALL equal !QueueFull && !FetchTQStop && state != RELOAD && Rest.
REQ-020 When AllocAble && FetchReq, WritePtr SHALL increment by 1; when FetchReq = 0, AllocAble SHALL be ignored.
REQ-021 Commit count = popcount(Inst1..4Commit), range 0-4; CommitPtr SHALL advance by that count.
REQ-022 If CommitPtr + count exceeds WritePtr, CommitPtr SHALL saturate at WritePtr and CommitErr SHALL set until reset.
REQ-023 The FSM SHALL have three states: IDLE (CommitPtr = UpdPtr), UPDATE (CommitPtr != UpdPtr), RELOAD (2 cycles, sub-counter R0/R1).
REQ-024 In UPDATE, exactly one entry SHALL be updated per cycle and UpdPtr SHALL increment at the edge.
REQ-025 Strobe generation in UPDATE is combinational from RdType:
  - UpBtbAble for types COND, JMP, CALL, RET, IND.
  - UpRasAble for CALL and RET.
  - UpTageAble for COND.
  - Type NONE or reserved: no strobe, but UpdPtr still advances.
REQ-026 Update latency: an entry committed at edge N SHALL be issued no earlier than the cycle following edge N.
REQ-027 On FetchTQFlash, WritePtr SHALL load FlashPtr, clamped to the post-commit CommitPtr if FlashPtr lies behind it, and the FSM SHALL enter RELOAD.R0.
REQ-028 In R0, UpRasReLoad = 1; in R1, UpTageReLoad = 1; after R1 the FSM SHALL go to UPDATE or IDLE per REQ-023.
REQ-029 No update strobes SHALL be issued in RELOAD, but commits SHALL still be accepted.
REQ-030 Simultaneous events SHALL resolve as follows:
  - flush + alloc: flush wins and the alloc is dropped.
  - flush + commit: the commit is applied first.
  - flush during RELOAD: RELOAD restarts at R0.
REQ-031 Simultaneous alloc and update at QueueFull SHALL NOT allocate, because FetchReq is evaluated pre-edge.
REQ-032 Pointer wrap at 2^PTRW SHALL be natural modulo arithmetic, with no special case.

Reset
REQ-033 Rest low SHALL immediately clear WritePtr, CommitPtr, UpdPtr and CommitErr to 0, and set the FSM to IDLE.
REQ-034 While Rest is low, all strobes and FetchReq SHALL be 0, QueueEmpty SHALL be 1 and QueueFull SHALL be 0.
REQ-035 Reset asserted mid-UPDATE or mid-RELOAD SHALL abort without completing pending strobes.

Structure
REQ-036 Package bpu_pkg SHALL hold QDEPTH, PTRW and the 3-bit type encoding: NONE=0, COND=1, JMP=2, CALL=3, RET=4, IND=5, 6-7 reserved.
REQ-037 The popcount/saturating commit adder SHALL be a single sub-module, bpu_commit_cnt; all else is flat.

Verification
REQ-038 Reset release, then 64 allocs with FetchTQStop=0 -> WritePtr=64 (0x40), QueueFull=1, FetchReq=0; a 65th alloc is ignored.
REQ-039 Allocate 4 entries typed COND, CALL, RET, NONE, then commit all 4 in one cycle -> over 4 consecutive cycles: {Btb,Tage}, {Btb,Ras}, {Btb,Ras}, {none}; UpdPtr=4, then IDLE.
REQ-040 WritePtr=10, CommitPtr=6, FetchTQFlash with FlashPtr=3 -> WritePtr=6 (clamped), UpRasReLoad next cycle, then UpTageReLoad, then IDLE.
REQ-041 WritePtr=2, CommitPtr=0, 4 commit flags set -> CommitPtr=2, CommitErr=1, and it stays set.
REQ-042 Pointers at 126, 126 allocs and commits across the wrap -> pointers reach 0x7E then 0x00 with the correct Full/Empty flags.
REQ-043 Rest dropped during UPDATE with 3 entries pending -> all strobes 0 in the same cycle, pointers 0, FSM IDLE.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared constants and encodings for the BPU update scheduler.
// Branch type codes match the BPU queue storage format.
package bpu_pkg;

    localparam int QDEPTH = 64;
    localparam int PTRW   = 7;

    typedef enum logic [2:0] {
        T_NONE = 3'd0,
        T_COND = 3'd1,
        T_JMP  = 3'd2,
        T_CALL = 3'd3,
        T_RET  = 3'd4,
        T_IND  = 3'd5
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_RELOAD
    } state_e;

endpackage

// File: rtl/bpu_commit_cnt.sv
// Popcount of the ROB commit flags and the saturating commit-pointer adder.
// An over-commit pins the pointer at the write pointer and raises over.
module bpu_commit_cnt #(
    parameter int PTRW = bpu_pkg::PTRW
) (
    input  logic [3:0]      commit,
    input  logic [PTRW-1:0] commit_ptr,
    input  logic [PTRW-1:0] write_ptr,
    output logic [PTRW-1:0] commit_ptr_n,
    output logic            over
);

    logic [2:0]      cnt;
    logic [PTRW-1:0] avail;

    always_comb begin
        cnt = 3'(commit[0]) + 3'(commit[1])
            + 3'(commit[2]) + 3'(commit[3]);
        avail = write_ptr - commit_ptr;
        over = PTRW'(cnt) > avail;
        commit_ptr_n = over ? write_ptr
                            : commit_ptr + PTRW'(cnt);
    end

endmodule

// File: rtl/bpu_update_sched.sv
// BPU queue pointer manager: allocation, commit, in-order predictor
// update and the two-cycle speculative-state reload after a flush.
module bpu_update_sched #(
    parameter int QDEPTH = bpu_pkg::QDEPTH,
    parameter int PTRW   = bpu_pkg::PTRW
) (
    input  logic            Clk,
    input  logic            Rest,
    input  logic            FetchTQStop,
    input  logic            FetchTQFlash,
    input  logic [PTRW-1:0] FlashPtr,
    input  logic            AllocAble,
    input  logic            Inst1Commit,
    input  logic            Inst2Commit,
    input  logic            Inst3Commit,
    input  logic            Inst4Commit,
    input  logic [2:0]      RdType,
    output logic            FetchReq,
    output logic [PTRW-1:0] WritePtr,
    output logic [PTRW-1:0] CommitPtr,
    output logic [PTRW-1:0] UpdPtr,
    output logic            QueueFull,
    output logic            QueueEmpty,
    output logic            UpBtbAble,
    output logic            UpRasAble,
    output logic            UpTageAble,
    output logic            UpRasReLoad,
    output logic            UpTageReLoad,
    output logic            CommitErr
);

    import bpu_pkg::*;

    state_e          state, state_n;
    logic            r_sub, r_sub_n;
    logic [PTRW-1:0] wptr, cptr, uptr;
    logic [PTRW-1:0] wptr_n, cptr_c, uptr_n;
    logic [PTRW-1:0] occ, fd, cd;
    logic            over, upd, err;

    assign WritePtr  = wptr;
    assign CommitPtr = cptr;
    assign UpdPtr    = uptr;
    assign CommitErr = err;

    assign occ        = wptr - uptr;
    assign QueueFull  = Rest && (occ == PTRW'(QDEPTH));
    assign QueueEmpty = !Rest || (occ == '0);
    assign FetchReq   = Rest && !QueueFull && !FetchTQStop
                      && (state != S_RELOAD);
    assign upd        = Rest && (state == S_UPDATE);

    bpu_commit_cnt #(
        .PTRW(PTRW)
    ) u_cnt (
        .commit      ({Inst4Commit, Inst3Commit,
                       Inst2Commit, Inst1Commit}),
        .commit_ptr  (cptr),
        .write_ptr   (wptr),
        .commit_ptr_n(cptr_c),
        .over        (over)
    );

    // Flush target is measured from UpdPtr so "behind commit" is wrap-safe.
    always_comb begin
        uptr_n = upd ? uptr + 1'b1 : uptr;
        fd = FlashPtr - uptr;
        cd = cptr_c - uptr;
        wptr_n = wptr;
        if (FetchTQFlash) begin
            if (fd < cd || fd > PTRW'(QDEPTH))
                wptr_n = cptr_c;
            else
                wptr_n = FlashPtr;
        end else if (AllocAble && FetchReq) begin
            wptr_n = wptr + 1'b1;
        end
    end

    always_comb begin
        state_n = S_IDLE;
        r_sub_n = 1'b0;
        if (FetchTQFlash) begin
            state_n = S_RELOAD;
        end else if (state == S_RELOAD && !r_sub) begin
            state_n = S_RELOAD;
            r_sub_n = 1'b1;
        end else if (cptr_c != uptr_n) begin
            state_n = S_UPDATE;
        end
    end

    always_comb begin
        UpBtbAble  = 1'b0;
        UpRasAble  = 1'b0;
        UpTageAble = 1'b0;
        if (upd) begin
            case (RdType)
                T_COND: begin
                    UpBtbAble  = 1'b1;
                    UpTageAble = 1'b1;
                end
                T_JMP, T_IND: UpBtbAble = 1'b1;
                T_CALL, T_RET: begin
                    UpBtbAble = 1'b1;
                    UpRasAble = 1'b1;
                end
                default: ;
            endcase
        end
        UpRasReLoad  = Rest && state == S_RELOAD && !r_sub;
        UpTageReLoad = Rest && state == S_RELOAD && r_sub;
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state <= S_IDLE;
            r_sub <= 1'b0;
            wptr  <= '0;
            cptr  <= '0;
            uptr  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            r_sub <= r_sub_n;
            wptr  <= wptr_n;
            cptr  <= cptr_c;
            uptr  <= uptr_n;
            err   <= err | over;
        end
    end

endmodule

// File: tb/tb_bpu_update_sched.sv
// Scoreboard bench for bpu_update_sched: strobe expectations are queued
// at commit/flush time and popped by a negedge monitor.
module tb_bpu_update_sched;

    logic       Clk = 1'b0;
    logic       Rest = 1'b0;
    logic       FetchTQStop = 1'b0;
    logic       FetchTQFlash = 1'b0;
    logic [6:0] FlashPtr = '0;
    logic       AllocAble = 1'b0;
    logic [3:0] cflags = '0;
    logic [2:0] RdType;
    logic       FetchReq;
    logic [6:0] WritePtr, CommitPtr, UpdPtr;
    logic       QueueFull, QueueEmpty;
    logic       UpBtbAble, UpRasAble, UpTageAble;
    logic       UpRasReLoad, UpTageReLoad, CommitErr;

    logic [2:0]  tq_type [64];
    logic [11:0] sb [$];
    logic [6:0]  m_cp = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 Clk = ~Clk;

    assign RdType = tq_type[UpdPtr[5:0]];

    bpu_update_sched dut (
        .Clk(Clk), .Rest(Rest),
        .FetchTQStop(FetchTQStop), .FetchTQFlash(FetchTQFlash),
        .FlashPtr(FlashPtr), .AllocAble(AllocAble),
        .Inst1Commit(cflags[0]), .Inst2Commit(cflags[1]),
        .Inst3Commit(cflags[2]), .Inst4Commit(cflags[3]),
        .RdType(RdType), .FetchReq(FetchReq),
        .WritePtr(WritePtr), .CommitPtr(CommitPtr), .UpdPtr(UpdPtr),
        .QueueFull(QueueFull), .QueueEmpty(QueueEmpty),
        .UpBtbAble(UpBtbAble), .UpRasAble(UpRasAble),
        .UpTageAble(UpTageAble), .UpRasReLoad(UpRasReLoad),
        .UpTageReLoad(UpTageReLoad), .CommitErr(CommitErr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_of(input logic [2:0] t);
        case (t)
            3'd1: return 3'b101;
            3'd2: return 3'b100;
            3'd3: return 3'b110;
            3'd4: return 3'b110;
            3'd5: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Monitor: {btb,ras,tage,rasrl,tagerl,UpdPtr}
    always @(negedge Clk) begin
        if (Rest && (UpBtbAble || UpRasAble || UpTageAble
                     || UpRasReLoad || UpTageReLoad)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe",
                    {UpBtbAble, UpRasAble, UpTageAble,
                     UpRasReLoad, UpTageReLoad, UpdPtr}, 32'h0);
            end else begin
                chk("strobe", {UpBtbAble, UpRasAble, UpTageAble,
                               UpRasReLoad, UpTageReLoad, UpdPtr},
                    32'(sb.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic alloc_n(input int n, input logic [2:0] t);
        for (int i = 0; i < n; i++) begin
            AllocAble = 1'b1;
            if (FetchReq) tq_type[WritePtr[5:0]] = t;
            cyc();
        end
        AllocAble = 1'b0;
    endtask

    task automatic commit_n(input int n);
        int k;
        logic [2:0] e;
        while (n > 0) begin
            k = (n > 4) ? 4 : n;
            for (int j = 0; j < k; j++) begin
                e = exp_of(tq_type[m_cp[5:0]]);
                if (e != 3'b000) sb.push_back({e, 2'b00, m_cp});
                m_cp = m_cp + 7'd1;
            end
            case (k)
                1: cflags = 4'b0100;
                2: cflags = 4'b1010;
                3: cflags = 4'b1011;
                default: cflags = 4'b1111;
            endcase
            cyc();
            cflags = '0;
            n -= k;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && UpdPtr != m_cp; i++) cyc();
        chk("drain_upd", UpdPtr, m_cp);
    endtask

    task automatic flush(input logic [6:0] fp, input logic [6:0] up);
        sb.push_back({5'b00010, up});
        sb.push_back({5'b00001, up});
        FetchTQFlash = 1'b1;
        FlashPtr = fp;
        AllocAble = 1'b1;
        cyc();
        FetchTQFlash = 1'b0;
        AllocAble = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) tq_type[i] = 3'd0;
        cyc();
        cyc();
        chk("rst_wptr", WritePtr, 0);
        chk("rst_cptr", CommitPtr, 0);
        chk("rst_uptr", UpdPtr, 0);
        chk("rst_flags", {QueueEmpty, QueueFull, FetchReq, CommitErr}, 4'b1000);
        chk("rst_strobes", {UpBtbAble, UpRasAble, UpTageAble,
                            UpRasReLoad, UpTageReLoad}, 0);
        Rest = 1'b1;
        #1;
        chk("rel_fetchreq", FetchReq, 1);

        // Fill to full, then a 65th alloc must be ignored.
        alloc_n(64, 3'd0);
        chk("full_wptr", WritePtr, 7'h40);
        chk("full_flags", {QueueFull, QueueEmpty, FetchReq}, 3'b100);
        alloc_n(1, 3'd0);
        chk("alloc65_wptr", WritePtr, 7'h40);
        commit_n(4);
        AllocAble = 1'b1;
        cyc();
        AllocAble = 1'b0;
        chk("full_alloc_upd_wptr", WritePtr, 7'h40);
        chk("full_alloc_upd_uptr", UpdPtr, 7'd1);
        commit_n(60);
        drain();
        chk("drained_empty", QueueEmpty, 1);

        // Typed entries committed in one cycle.
        alloc_n(1, 3'd1);
        alloc_n(1, 3'd3);
        alloc_n(1, 3'd4);
        alloc_n(1, 3'd0);
        commit_n(4);
        drain();
        chk("typed_uptr", UpdPtr, 7'd68);
        chk("typed_empty", QueueEmpty, 1);
        alloc_n(1, 3'd2);
        alloc_n(1, 3'd5);
        alloc_n(1, 3'd7);
        commit_n(3);
        drain();
        chk("typed2_uptr", UpdPtr, 7'd71);

        // Flush behind the commit pointer clamps; alloc in flush is dropped.
        alloc_n(10, 3'd0);
        commit_n(6);
        drain();
        flush(7'd74, 7'd77);
        chk("flush_clamp_wptr", WritePtr, 7'd77);
        chk("reload_fetchreq", FetchReq, 0);
        cyc();
        cyc();
        chk("post_reload_fetchreq", FetchReq, 1);
        chk("post_reload_empty", QueueEmpty, 1);

        // Flush ahead of commit is taken as-is, then over-commit.
        alloc_n(4, 3'd0);
        flush(7'd79, 7'd77);
        chk("flush_noclamp_wptr", WritePtr, 7'd79);
        cyc();
        cyc();
        commit_n(4);
        m_cp = 7'd79;
        chk("overcommit_cptr", CommitPtr, 7'd79);
        chk("overcommit_err", CommitErr, 1);
        drain();
        cyc();
        cyc();
        chk("err_sticky", CommitErr, 1);

        Rest = 1'b0;
        #1;
        chk("rst2_err", CommitErr, 0);
        m_cp = '0;
        cyc();
        Rest = 1'b1;

        FetchTQStop = 1'b1;
        #1;
        chk("stop_fetchreq", FetchReq, 0);
        alloc_n(1, 3'd0);
        chk("stop_wptr", WritePtr, 0);
        FetchTQStop = 1'b0;

        // Walk pointers up to 0x7E, then across the wrap.
        for (int i = 0; i < 63; i++) begin
            alloc_n(2, 3'd0);
            commit_n(2);
        end
        drain();
        chk("wrap_pre_wptr", WritePtr, 7'h7E);
        chk("wrap_pre_empty", QueueEmpty, 1);
        alloc_n(2, 3'd0);
        chk("wrap_wptr", WritePtr, 7'h00);
        chk("wrap_flags", {QueueFull, QueueEmpty}, 2'b00);
        alloc_n(62, 3'd0);
        chk("wrap_full_wptr", WritePtr, 7'd62);
        chk("wrap_full", QueueFull, 1);
        commit_n(64);
        drain();
        chk("wrap_cptr", CommitPtr, 7'd62);
        chk("wrap_empty", QueueEmpty, 1);

        // Reset mid-UPDATE with entries still pending.
        alloc_n(3, 3'd1);
        commit_n(3);
        @(posedge Clk);
        #2;
        Rest = 1'b0;
        #1;
        chk("abort_strobes", {UpBtbAble, UpRasAble, UpTageAble,
                              UpRasReLoad, UpTageReLoad}, 0);
        chk("abort_ptrs", {WritePtr, CommitPtr, UpdPtr}, 0);
        chk("abort_flags", {QueueEmpty, FetchReq}, 2'b10);
        chk("abort_pending", sb.size(), 2);
        sb.delete();
        m_cp = '0;
        cyc();
        Rest = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("final_uptr", UpdPtr, 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
